// File: rtl/alu_exec_stage_if.sv
// Bundle between the execute stage and its neighbours: op handshake,
// register-file read ports, writeback port and status flags.
interface alu_exec_stage_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) ();
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic [ADDR_W-1:0] in_rd;
    logic [ADDR_W-1:0] rf_raddr1;
    logic [ADDR_W-1:0] rf_raddr2;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_data;
    logic              flag_z;
    logic              flag_c;
    logic              busy;

    // Upstream/register-file side.
    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_rd, rf_rdata1, rf_rdata2,
        input  in_ready, rf_raddr1, rf_raddr2, wb_we, wb_dest, wb_data,
               flag_z, flag_c, busy
    );

    // Execute stage side.
    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_rd, rf_rdata1, rf_rdata2,
        output in_ready, rf_raddr1, rf_raddr2, wb_we, wb_dest, wb_data,
               flag_z, flag_c, busy
    );
endinterface

// File: rtl/alu_exec_stage.sv
// ALU execute stage: single-cycle ops with writeback forwarding, plus an
// iterative shift-add multiplier that takes DATA_W cycles.
module alu_exec_stage #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input logic             clk,
    input logic             rst,
    alu_exec_stage_if.slave bus
);
    localparam int unsigned CntW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned ProdW = 2 * DATA_W;

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpAnd = 3'd2;
    localparam logic [2:0] OpOr  = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpShl = 3'd5;
    localparam logic [2:0] OpShr = 3'd6;
    localparam logic [2:0] OpMul = 3'd7;

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ProdW-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] mul_a_q, mul_a_d;
    logic [DATA_W-1:0] mul_b_q, mul_b_d;
    logic [ADDR_W-1:0] mul_rd_q, mul_rd_d;
    logic              wb_we_q, wb_we_d;
    logic [ADDR_W-1:0] wb_dest_q, wb_dest_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              flag_z_q, flag_z_d;
    logic              flag_c_q, flag_c_d;

    logic [DATA_W-1:0] op_a, op_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic [DATA_W:0]   alu_wide;
    logic [ProdW-1:0]  acc_step;

    assign bus.rf_raddr1 = bus.in_rs1;
    assign bus.rf_raddr2 = bus.in_rs2;
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.busy      = (state_q == StMul);
    assign bus.wb_we     = wb_we_q;
    assign bus.wb_dest   = wb_dest_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.flag_z    = flag_z_q;
    assign bus.flag_c    = flag_c_q;

    // Forward the result currently being written back over stale read data.
    always_comb begin
        op_a = (wb_we_q && (wb_dest_q == bus.in_rs1)) ? wb_data_q : bus.rf_rdata1;
        op_b = (wb_we_q && (wb_dest_q == bus.in_rs2)) ? wb_data_q : bus.rf_rdata2;
    end

    // Single-cycle ALU result and carry/borrow.
    always_comb begin
        alu_wide = '0;
        alu_res  = '0;
        alu_c    = 1'b0;
        case (bus.in_op)
            OpAdd: begin
                alu_wide = {1'b0, op_a} + {1'b0, op_b};
                alu_res  = alu_wide[DATA_W-1:0];
                alu_c    = alu_wide[DATA_W];
            end
            OpSub: begin
                // Top bit of the widened difference is the borrow.
                alu_wide = {1'b0, op_a} - {1'b0, op_b};
                alu_res  = alu_wide[DATA_W-1:0];
                alu_c    = alu_wide[DATA_W];
            end
            OpAnd: alu_res = op_a & op_b;
            OpOr:  alu_res = op_a | op_b;
            OpXor: alu_res = op_a ^ op_b;
            OpShl: begin
                alu_res = {op_a[DATA_W-2:0], 1'b0};
                alu_c   = op_a[DATA_W-1];
            end
            OpShr: begin
                alu_res = {1'b0, op_a[DATA_W-1:1]};
                alu_c   = op_a[0];
            end
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
            end
        endcase
    end

    // One shift-add multiply step for the current counter bit.
    always_comb begin
        acc_step = acc_q;
        if (mul_b_q[cnt_q]) begin
            acc_step = acc_q + ({{DATA_W{1'b0}}, mul_a_q} << cnt_q);
        end
    end

    // Next-state: accept ops in idle, iterate the multiplier, emit writebacks.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        mul_rd_d  = mul_rd_q;
        wb_we_d   = 1'b0;
        wb_dest_d = wb_dest_q;
        wb_data_d = wb_data_q;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    if (bus.in_op == OpMul) begin
                        mul_a_d  = op_a;
                        mul_b_d  = op_b;
                        mul_rd_d = bus.in_rd;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = StMul;
                    end else begin
                        wb_we_d   = 1'b1;
                        wb_dest_d = bus.in_rd;
                        wb_data_d = alu_res;
                        flag_z_d  = (alu_res == '0);
                        flag_c_d  = alu_c;
                    end
                end
            end
            StMul: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(DATA_W - 1)) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    wb_we_d   = 1'b1;
                    wb_dest_d = mul_rd_q;
                    wb_data_d = acc_step[DATA_W-1:0];
                    flag_z_d  = (acc_step[DATA_W-1:0] == '0);
                    flag_c_d  = |acc_step[ProdW-1:DATA_W];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; reset also aborts a multiply.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            mul_rd_q  <= '0;
            wb_we_q   <= 1'b0;
            wb_dest_q <= '0;
            wb_data_q <= '0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            mul_rd_q  <= mul_rd_d;
            wb_we_q   <= wb_we_d;
            wb_dest_q <= wb_dest_d;
            wb_data_q <= wb_data_d;
            flag_z_q  <= flag_z_d;
            flag_c_q  <= flag_c_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a behavioural reference model.
module tb_alu_exec_stage;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int          MASK   = (1 << DATA_W) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_exec_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    alu_exec_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: what the outputs must be after each edge.
    bit m_init = 0;
    bit m_we   = 0;
    int m_dest = 0;
    int m_data = 0;
    bit m_z    = 0;
    bit m_c    = 0;
    int m_mul_left = 0;
    int m_mul_rd   = 0;
    int m_mul_res  = 0;
    bit m_mul_c    = 0;

    function automatic void model_alu(input int op, input int a, input int b,
                                      output int r, output bit c);
        int full;
        c = 0;
        r = 0;
        case (op)
            0: begin full = a + b; r = full & MASK; c = (full > MASK); end
            1: begin r = (a - b) & MASK; c = (a < b); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = (a << 1) & MASK; c = ((a >> (DATA_W - 1)) & 1) != 0; end
            6: begin r = a >> 1; c = (a & 1) != 0; end
            default: begin full = a * b; r = full & MASK; c = ((full >> DATA_W) != 0); end
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_step();
        int a, b, r;
        bit c, prev_we;
        m_init = 1;
        if (rst) begin
            m_we = 0; m_dest = 0; m_data = 0; m_z = 0; m_c = 0; m_mul_left = 0;
            return;
        end
        prev_we = m_we;
        m_we    = 0;
        if (m_mul_left > 0) begin
            m_mul_left--;
            if (m_mul_left == 0) begin
                m_we = 1; m_dest = m_mul_rd; m_data = m_mul_res;
                m_z = (m_mul_res == 0); m_c = m_mul_c;
            end
        end else if (bus.in_valid) begin
            a = (prev_we && m_dest == int'(bus.in_rs1)) ? m_data : int'(bus.rf_rdata1);
            b = (prev_we && m_dest == int'(bus.in_rs2)) ? m_data : int'(bus.rf_rdata2);
            model_alu(int'(bus.in_op), a, b, r, c);
            if (bus.in_op == 3'd7) begin
                m_mul_left = DATA_W; m_mul_rd = bus.in_rd; m_mul_res = r; m_mul_c = c;
            end else begin
                m_we = 1; m_dest = bus.in_rd; m_data = r; m_z = (r == 0); m_c = c;
            end
        end
    endtask

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (m_init) begin
            check("wb_we",    bus.wb_we,    m_we);
            check("wb_dest",  bus.wb_dest,  m_dest);
            check("wb_data",  bus.wb_data,  m_data);
            check("flag_z",   bus.flag_z,   m_z);
            check("flag_c",   bus.flag_c,   m_c);
            check("in_ready", bus.in_ready, (m_mul_left == 0));
            check("busy",     bus.busy,     (m_mul_left != 0));
            check("raddr1",   bus.rf_raddr1, bus.in_rs1);
            check("raddr2",   bus.rf_raddr2, bus.in_rs2);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_op(input int op, input int rs1, input int rs2, input int rd,
                          input int d1, input int d2);
        bus.in_valid  = 1'b1;
        bus.in_op     = 3'(op);
        bus.in_rs1    = ADDR_W'(rs1);
        bus.in_rs2    = ADDR_W'(rs2);
        bus.in_rd     = ADDR_W'(rd);
        bus.rf_rdata1 = DATA_W'(d1);
        bus.rf_rdata2 = DATA_W'(d2);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // Directed logic/arith vectors: op, a, b, expected result, z, c.
    typedef struct {
        int op; int a; int b; int r; bit z; bit c;
    } vec_t;
    vec_t vecs[5] = '{
        '{2, 'hF0, 'h3C, 'h30, 0, 0},
        '{3, 'hF0, 'h0F, 'hFF, 0, 0},
        '{4, 'hAA, 'hAA, 'h00, 1, 0},
        '{0, 'hFF, 'h01, 'h00, 1, 1},
        '{1, 'h00, 'h01, 'hFF, 0, 1}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit found;
        int seen;
        rst = 1'b1;
        idle();
        set_op(0, 0, 0, 0, 0, 0);
        idle();
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", bus.in_ready, 1);
        check("rst_busy",  bus.busy, 0);
        check("rst_we",    bus.wb_we, 0);

        // ADD with carry out.
        set_op(0, 1, 2, 3, 'hF0, 'h20);
        tick();
        check("add_we", bus.wb_we, 1);
        check("add_dest", bus.wb_dest, 3);
        check("add_data", bus.wb_data, 'h10);
        check("add_c", bus.flag_c, 1);
        check("add_z", bus.flag_z, 0);
        idle();
        tick();
        check("add_we_drop", bus.wb_we, 0);
        check("add_data_hold", bus.wb_data, 'h10);

        // Back-to-back SUBs: zero result, then borrow.
        set_op(1, 5, 6, 2, 'h05, 'h05);
        tick();
        check("sub0_data", bus.wb_data, 'h00);
        check("sub0_z", bus.flag_z, 1);
        check("sub0_c", bus.flag_c, 0);
        set_op(1, 5, 6, 4, 'h03, 'h05);
        tick();
        check("sub1_we", bus.wb_we, 1);
        check("sub1_data", bus.wb_data, 'hFE);
        check("sub1_z", bus.flag_z, 0);
        check("sub1_c", bus.flag_c, 1);

        // Forwarding: single source, then both sources.
        set_op(0, 1, 2, 1, 'h07, 'h01);
        tick();
        check("fwd_add", bus.wb_data, 'h08);
        set_op(4, 1, 0, 5, 'h00, 'hFF);
        tick();
        check("fwd_xor", bus.wb_data, 'hF7);
        set_op(0, 5, 5, 6, 'h00, 'h00);
        tick();
        check("fwd_both_data", bus.wb_data, 'hEE);
        check("fwd_both_c", bus.flag_c, 1);
        check("fwd_both_dest", bus.wb_dest, 6);

        // Logic/arith table, issued back-to-back.
        foreach (vecs[i]) begin
            set_op(vecs[i].op, 0, 1, 7, vecs[i].a, vecs[i].b);
            tick();
            check("vec_data", bus.wb_data, vecs[i].r);
            check("vec_z", bus.flag_z, vecs[i].z);
            check("vec_c", bus.flag_c, vecs[i].c);
        end

        // Shifts.
        set_op(5, 2, 3, 1, 'h81, 'h00);
        tick();
        check("shl_data", bus.wb_data, 'h02);
        check("shl_c", bus.flag_c, 1);
        set_op(6, 2, 3, 2, 'h01, 'h00);
        tick();
        check("shr_data", bus.wb_data, 'h00);
        check("shr_z", bus.flag_z, 1);
        check("shr_c", bus.flag_c, 1);
        idle();
        tick();

        // MUL 0x0D * 0x0B with an ignored op pulsed while busy.
        set_op(7, 1, 2, 7, 'h0D, 'h0B);
        tick();
        for (int k = 1; k <= DATA_W; k++) begin
            check("mul_ready_low", bus.in_ready, 0);
            check("mul_busy", bus.busy, 1);
            check("mul_no_we", bus.wb_we, 0);
            if (k == 3 || k == 4) set_op(0, 3, 4, 0, 'h11, 'h22);
            else idle();
            tick();
        end
        check("mul_we", bus.wb_we, 1);
        check("mul_dest", bus.wb_dest, 7);
        check("mul_data", bus.wb_data, 'h8F);
        check("mul_c", bus.flag_c, 0);
        check("mul_ready", bus.in_ready, 1);
        idle();
        tick();
        check("mul_ignored", bus.wb_we, 0);
        check("mul_dest_hold", bus.wb_dest, 7);

        // MUL with overflow into the upper half.
        set_op(7, 1, 2, 3, 'h20, 'h10);
        tick();
        idle();
        found = 0;
        lat = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus.wb_we) begin
                found = 1;
                lat = i + 1;
            end
        end
        check("mul2_done", found, 1);
        check("mul2_latency", lat, DATA_W);
        check("mul2_data", bus.wb_data, 'h00);
        check("mul2_z", bus.flag_z, 1);
        check("mul2_c", bus.flag_c, 1);
        idle();
        tick();

        // Reset in the middle of a multiply.
        set_op(7, 0, 1, 5, 'hFF, 'hFF);
        tick();
        idle();
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("abort_ready", bus.in_ready, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_z", bus.flag_z, 0);
        check("abort_c", bus.flag_c, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.wb_we) seen++;
        end
        check("abort_no_wb", seen, 0);

        // Stage recovers after reset.
        set_op(0, 0, 1, 0, 'h01, 'h02);
        tick();
        check("post_rst_data", bus.wb_data, 'h03);
        check("post_rst_dest", bus.wb_dest, 0);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
